// File: rtl/irq_sched.sv
// ---------------------------------------------------------------------------
// irq_sched: memory-mapped machine timer / software / external interrupt
// scheduler for a single hart.
//
// Register map (byte offsets on req_addr):
//   0x0000 msip      bit0 only, bits 63:1 read as 0
//   0x4000 mtimecmp  64-bit compare value
//   0xBFF8 mtime     64-bit free-running timer
// Any other offset returns 0 on a read, drops a write, and raises resp_err.
//
// Ports:
//   clk, reset              clock; synchronous active-high reset
//   req_valid/req_write/req_addr/req_wdata/req_ready
//                           request side; accepted when req_valid && req_ready
//   resp_valid/resp_rdata/resp_err
//                           one-cycle response, the cycle after acceptance
//   ext_irq_in              asynchronous external interrupt line
//   ext_ack                 clears the external pending bit
//   trint/swint/exint       registered interrupt lines to the CSR unit
//
// Build option: define IRQ_PRESCALE_EN to advance mtime once every MTIME_DIV
// clocks instead of every clock.
// ---------------------------------------------------------------------------
module irq_sched #(
  parameter int unsigned SYNC_STAGES = 2,  // 2 or 3
  parameter int unsigned MTIME_DIV   = 4   // 2..255, used with IRQ_PRESCALE_EN
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  input  logic        req_write,
  input  logic [15:0] req_addr,
  input  logic [63:0] req_wdata,
  output logic        req_ready,
  output logic        resp_valid,
  output logic [63:0] resp_rdata,
  output logic        resp_err,
  input  logic        ext_irq_in,
  input  logic        ext_ack,
  output logic        trint,
  output logic        swint,
  output logic        exint
);

  localparam logic [15:0] ADDR_MSIP     = 16'h0000;
  localparam logic [15:0] ADDR_MTIMECMP = 16'h4000;
  localparam logic [15:0] ADDR_MTIME    = 16'hBFF8;

  typedef enum logic {ST_IDLE, ST_RESP} state_t;

  state_t state_q, state_d;
  logic   accept;

  logic [63:0] mtime_q, mtime_d;
  logic [63:0] mtimecmp_q, mtimecmp_d;
  logic        msip_q, msip_d;
  logic        tick;

  logic        hit_msip, hit_cmp, hit_mtime, hit_any;
  logic [63:0] rd_data;
  logic        wr_msip, wr_cmp, wr_mtime;

  logic        resp_valid_q, resp_err_q;
  logic [63:0] resp_rdata_q;
  logic        trint_q, swint_q, exint_q;

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   sync_prev_q;
  logic                   irq_rise;
  logic                   ext_pend_q, ext_pend_d;

  // ---------------- request FSM ----------------
  always_comb begin
    state_d = state_q;
    accept  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (req_valid && !reset) begin
          accept  = 1'b1;
          state_d = ST_RESP;
        end
      end
      ST_RESP: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  // ---------------- address decode / read mux ----------------
  always_comb begin
    hit_msip  = (req_addr == ADDR_MSIP);
    hit_cmp   = (req_addr == ADDR_MTIMECMP);
    hit_mtime = (req_addr == ADDR_MTIME);
    hit_any   = hit_msip | hit_cmp | hit_mtime;
    rd_data   = 64'd0;
    if (hit_msip)  rd_data = {63'd0, msip_q};
    if (hit_cmp)   rd_data = mtimecmp_q;
    if (hit_mtime) rd_data = mtime_q;
  end

  assign wr_msip  = accept & req_write & hit_msip;
  assign wr_cmp   = accept & req_write & hit_cmp;
  assign wr_mtime = accept & req_write & hit_mtime;

  // ---------------- mtime advance ----------------
`ifdef IRQ_PRESCALE_EN
  localparam logic [7:0] DIV_LAST = 8'(MTIME_DIV - 1);
  logic [7:0] div_q, div_d;

  assign tick = (div_q == DIV_LAST);

  // A write to mtime restarts the prescale period so the written value
  // is held for a full MTIME_DIV clocks.
  always_comb begin
    div_d = div_q + 8'd1;
    if (wr_mtime || tick) div_d = 8'd0;
  end

  always_ff @(posedge clk) begin
    if (reset) div_q <= 8'd0;
    else       div_q <= div_d;
  end
`else
  localparam logic [7:0] DIV_LAST = 8'(MTIME_DIV - 1);
  logic unused_div;
  assign unused_div = ^DIV_LAST;
  assign tick       = 1'b1;
`endif

  // A same-cycle write overrides the increment.
  always_comb begin
    mtime_d    = tick ? (mtime_q + 64'd1) : mtime_q;
    mtimecmp_d = mtimecmp_q;
    msip_d     = msip_q;
    if (wr_mtime) mtime_d    = req_wdata;
    if (wr_cmp)   mtimecmp_d = req_wdata;
    if (wr_msip)  msip_d     = req_wdata[0];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      mtime_q    <= 64'd0;
      mtimecmp_q <= {64{1'b1}};
      msip_q     <= 1'b0;
    end else begin
      mtime_q    <= mtime_d;
      mtimecmp_q <= mtimecmp_d;
      msip_q     <= msip_d;
    end
  end

  // ---------------- response registers ----------------
  // Read data is sampled from the current register values at acceptance,
  // i.e. before this cycle's increment or write lands.
  always_ff @(posedge clk) begin
    if (reset) begin
      resp_valid_q <= 1'b0;
      resp_err_q   <= 1'b0;
      resp_rdata_q <= 64'd0;
    end else if (accept) begin
      resp_valid_q <= 1'b1;
      resp_err_q   <= ~hit_any;
      resp_rdata_q <= req_write ? 64'd0 : rd_data;
    end else begin
      resp_valid_q <= 1'b0;
    end
  end

  // ---------------- external interrupt path ----------------
  always_ff @(posedge clk) begin
    if (reset) begin
      sync_q      <= '0;
      sync_prev_q <= 1'b0;
    end else begin
      sync_q      <= {sync_q[SYNC_STAGES-2:0], ext_irq_in};
      sync_prev_q <= sync_q[SYNC_STAGES-1];
    end
  end

  assign irq_rise = sync_q[SYNC_STAGES-1] & ~sync_prev_q;

  // A new edge beats a simultaneous acknowledge so no interrupt is lost.
  always_comb begin
    ext_pend_d = ext_pend_q;
    if (ext_ack)  ext_pend_d = 1'b0;
    if (irq_rise) ext_pend_d = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) ext_pend_q <= 1'b0;
    else       ext_pend_q <= ext_pend_d;
  end

  // ---------------- interrupt outputs ----------------
  always_ff @(posedge clk) begin
    if (reset) begin
      trint_q <= 1'b0;
      swint_q <= 1'b0;
      exint_q <= 1'b0;
    end else begin
      trint_q <= (mtime_q >= mtimecmp_q);
      swint_q <= msip_q;
      exint_q <= ext_pend_q;
    end
  end

  // Outputs are forced to their idle values while reset is asserted so a
  // response in flight when reset arrives is never seen.
  assign req_ready  = (state_q == ST_IDLE) | reset;
  assign resp_valid = resp_valid_q & ~reset;
  assign resp_err   = resp_err_q & ~reset;
  assign resp_rdata = reset ? 64'd0 : resp_rdata_q;
  assign trint      = trint_q & ~reset;
  assign swint      = swint_q & ~reset;
  assign exint      = exint_q & ~reset;

endmodule

// File: tb/tb_irq_sched.sv
// ---------------------------------------------------------------------------
// tb_irq_sched: self-checking bench for irq_sched.
// A reference model (timer as base + elapsed/div, interrupt line as a sample
// history) advances on each rising edge; a compare process checks every DUT
// output on each falling edge. Directed sequences pin the model with literal
// expectations, then randomized traffic runs against the model.
// ---------------------------------------------------------------------------
module tb_irq_sched;

  localparam int SYNC = 2;
  localparam int DIV  = 4;
`ifdef IRQ_PRESCALE_EN
  localparam int M_DIV = DIV;
`else
  localparam int M_DIV = 1;
`endif
  localparam logic [63:0] ONES = {64{1'b1}};

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid, req_write;
  logic [15:0] req_addr;
  logic [63:0] req_wdata;
  logic        req_ready, resp_valid, resp_err;
  logic [63:0] resp_rdata;
  logic        ext_irq_in, ext_ack;
  logic        trint, swint, exint;

  irq_sched #(.SYNC_STAGES(SYNC), .MTIME_DIV(DIV)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_write(req_write), .req_addr(req_addr),
    .req_wdata(req_wdata), .req_ready(req_ready),
    .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err),
    .ext_irq_in(ext_irq_in), .ext_ack(ext_ack),
    .trint(trint), .swint(swint), .exint(exint)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  bit done   = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h t=%0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  logic [63:0] m_base, m_elapsed, m_cmp, m_rdata;
  logic        m_msip, m_pend, m_in_resp, m_rv, m_err, m_rd_chk;
  logic        m_tr, m_sw, m_ex;
  logic        m_hist [0:SYNC+1];
  bit          m_en = 1'b0;

  function automatic logic [63:0] m_mtime();
    return m_base + m_elapsed / M_DIV;
  endfunction

  task automatic model_step();
    logic [63:0] cur;
    logic        rise, mapped;
    cur = m_mtime();
    if (reset) begin
      m_base = 0; m_elapsed = 0; m_cmp = ONES; m_msip = 0; m_pend = 0;
      for (int j = 0; j <= SYNC + 1; j++) m_hist[j] = 0;
      m_in_resp = 0; m_rv = 0; m_err = 0; m_rdata = 0; m_rd_chk = 1;
      m_tr = 0; m_sw = 0; m_ex = 0;
      m_en = 1'b1;
    end else if (m_en) begin
      m_tr = (cur >= m_cmp);
      m_sw = m_msip;
      m_ex = m_pend;
      rise = m_hist[SYNC] && !m_hist[SYNC+1];
      if (rise)         m_pend = 1;
      else if (ext_ack) m_pend = 0;
      for (int j = SYNC + 1; j >= 2; j--) m_hist[j] = m_hist[j-1];
      m_hist[1] = ext_irq_in;
      mapped = (req_addr == 16'h0000) || (req_addr == 16'h4000) || (req_addr == 16'hBFF8);
      if (m_in_resp) begin
        m_in_resp = 0; m_rv = 0;
        m_elapsed = m_elapsed + 1;
      end else if (req_valid) begin
        m_in_resp = 1; m_rv = 1; m_err = !mapped; m_rd_chk = !req_write;
        if (!req_write) begin
          case (req_addr)
            16'h0000: m_rdata = {63'd0, m_msip};
            16'h4000: m_rdata = m_cmp;
            16'hBFF8: m_rdata = cur;
            default:  m_rdata = 0;
          endcase
        end
        if (req_write && req_addr == 16'h0000) m_msip = req_wdata[0];
        if (req_write && req_addr == 16'h4000) m_cmp = req_wdata;
        if (req_write && req_addr == 16'hBFF8) begin
          m_base = req_wdata; m_elapsed = 0;
        end else begin
          m_elapsed = m_elapsed + 1;
        end
      end else begin
        m_rv = 0;
        m_elapsed = m_elapsed + 1;
      end
    end
  endtask

  initial forever begin
    @(posedge clk);
    model_step();
  end

  // ---------------- per-cycle compare ----------------
  initial forever begin
    @(negedge clk);
    if (m_en && !done) begin
      if (reset) begin
        chk("rst_ready", req_ready, 1);
        chk("rst_rvalid", resp_valid, 0);
        chk("rst_rdata", resp_rdata, 0);
        chk("rst_err", resp_err, 0);
        chk("rst_trint", trint, 0);
        chk("rst_swint", swint, 0);
        chk("rst_exint", exint, 0);
      end else begin
        chk("ready", req_ready, !m_in_resp);
        chk("rvalid", resp_valid, m_rv);
        if (m_rv) chk("err", resp_err, m_err);
        if (m_rv && m_rd_chk) chk("rdata", resp_rdata, m_rdata);
        chk("trint", trint, m_tr);
        chk("swint", swint, m_sw);
        chk("exint", exint, m_ex);
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic xact(input logic w, input logic [15:0] a, input logic [63:0] d,
                      output logic [63:0] rd, output logic e);
    req_valid = 1; req_write = w; req_addr = a; req_wdata = d;
    @(posedge clk); #2;
    req_valid = 0;
    @(negedge clk);
    chk("xact_rvalid", resp_valid, 1);
    rd = resp_rdata;
    e  = resp_err;
    @(posedge clk); #2;
  endtask

  logic [63:0] rd;
  logic        e;
  int          n, accepts;

  initial begin
    reset = 1; req_valid = 0; req_write = 0; req_addr = 0; req_wdata = 0;
    ext_irq_in = 0; ext_ack = 0;
    repeat (3) @(posedge clk);
    #2 reset = 0;

    // read mtimecmp straight after reset
    xact(0, 16'h4000, 0, rd, e);
    chk("cmp_reset_val", rd, ONES);
    chk("cmp_reset_err", e, 0);
    chk("cmp_reset_trint", trint, 0);

    // msip write/readback and swint
    xact(1, 16'h0000, ONES, rd, e);
    @(negedge clk); chk("swint_set", swint, 1);
    @(posedge clk); #2;
    xact(0, 16'h0000, 0, rd, e);
    chk("msip_read", rd, 64'd1);
    xact(1, 16'h0000, 0, rd, e);
    @(negedge clk); chk("swint_clr", swint, 0);
    @(posedge clk); #2;

    // mtime wrap
    xact(1, 16'hBFF8, 64'hFFFF_FFFF_FFFF_FFFE, rd, e);
    @(posedge clk); #2;
    xact(0, 16'hBFF8, 0, rd, e);
`ifndef IRQ_PRESCALE_EN
    chk("mtime_wrap_read", rd, 64'd0);
`endif

    // timer interrupt with mtimecmp = 20
    xact(1, 16'hBFF8, 0, rd, e);
    xact(1, 16'h4000, 64'd20, rd, e);
    n = 0;
    while (n < 200) begin
      @(negedge clk);
      n++;
      if (trint) break;
    end
`ifndef IRQ_PRESCALE_EN
    chk("trint_rise_cycle", n, 19);
`endif
    for (int i = 0; i < 5; i++) begin
      @(negedge clk); chk("trint_hold", trint, 1);
    end
    @(posedge clk); #2;
    xact(1, 16'h4000, ONES, rd, e);
    @(negedge clk); chk("trint_clear", trint, 0);
    @(posedge clk); #2;

    // external interrupt latency
    ext_irq_in = 1;
    @(negedge clk); chk("exint_lat", exint, 0);
    @(posedge clk); #2; ext_irq_in = 0;
    for (int k = 1; k <= SYNC + 2; k++) begin
      @(negedge clk); chk("exint_lat", exint, (k == SYNC + 2));
      @(posedge clk); #2;
    end
    // ack coinciding with a fresh edge: set wins
    ext_irq_in = 1;
    for (int k = 0; k <= SYNC + 4; k++) begin
      @(negedge clk); chk("exint_ack_vs_edge", exint, 1);
      @(posedge clk); #2;
      if (k == 0) ext_irq_in = 0;
      if (k == SYNC - 1) ext_ack = 1;
      if (k == SYNC) ext_ack = 0;
    end
    ext_ack = 1;
    @(posedge clk); #2; ext_ack = 0;
    @(negedge clk); chk("exint_ack_lag", exint, 1);
    @(posedge clk); #2;
    @(negedge clk); chk("exint_acked", exint, 0);
    @(posedge clk); #2;

    // req_valid held 4 cycles on an unmapped address
    req_valid = 1; req_write = 0; req_addr = 16'h1234;
    accepts = 0;
    for (int k = 1; k <= 4; k++) begin
      @(posedge clk); #2;
      if (k == 4) req_valid = 0;
      @(negedge clk);
      chk("hold_ready", req_ready, (k % 2 == 0));
      if (k % 2 == 1) chk("hold_err", resp_err, 1);
      if (resp_valid) accepts++;
    end
    chk("hold_accepts", accepts, 2);
    @(posedge clk); #2;

    // reset in the middle of a transaction drops the response
    req_valid = 1; req_write = 0; req_addr = 16'h4000;
    @(posedge clk); #2;
    req_valid = 0; reset = 1;
    @(negedge clk); chk("midrst_rvalid", resp_valid, 0);
    @(posedge clk); #2; reset = 0;
    @(negedge clk); chk("midrst_rvalid2", resp_valid, 0);
    chk("midrst_ready", req_ready, 1);
    @(posedge clk); #2;

    // randomized traffic
    for (int c = 0; c < 4000; c++) begin
      reset     = ($urandom_range(0, 399) == 0);
      req_valid = $urandom_range(0, 1);
      req_write = $urandom_range(0, 1);
      case ($urandom_range(0, 4))
        0: req_addr = 16'h0000;
        1, 2: req_addr = 16'h4000;
        3: req_addr = 16'hBFF8;
        default: req_addr = 16'($urandom);
      endcase
      req_wdata = {$urandom, $urandom};
      if (req_addr == 16'h4000 && $urandom_range(0, 3) != 0)
        req_wdata = m_mtime() + 64'($urandom_range(0, 40)) - 64'd10;
      if (req_addr == 16'hBFF8 && $urandom_range(0, 1) == 1)
        req_wdata = ONES - 64'($urandom_range(0, 8));
      if ($urandom_range(0, 5) == 0) ext_irq_in = ~ext_irq_in;
      ext_ack = ($urandom_range(0, 7) == 0);
      @(posedge clk); #2;
    end
    reset = 0; req_valid = 0; ext_ack = 0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    done = 1'b1;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/irq_sched.md
IRQ_SCHED -- requirements
Module: irq_sched

Interface
REQ-001 SHALL have parameter SYNC_STAGES, default 2, number of synchronizer flops on ext_irq_in (legal values 2 or 3).
REQ-002 SHALL have parameter MTIME_DIV, default 4, clk cycles per mtime tick when IRQ_PRESCALE_EN is defined (legal range 2..255).
REQ-003 SHALL have port clk  in  1  clock; all state updates on its rising edge.
REQ-004 SHALL have port reset  in  1  reset: synchronous, active-high.
REQ-005 SHALL have port req_valid  in  1  MMIO request present.
REQ-006 SHALL have port req_write  in  1  1 = write, 0 = read.
REQ-007 SHALL have port req_addr  in  16  byte offset of the register.
REQ-008 SHALL have port req_wdata  in  64  write data.
REQ-009 SHALL have port req_ready  out  1  request can be accepted this cycle.
REQ-010 SHALL have port resp_valid  out  1  response strobe.
REQ-011 SHALL have port resp_rdata  out  64  read data.
REQ-012 SHALL have port resp_err  out  1  unmapped address flag.
REQ-013 SHALL have port ext_irq_in  in  1  asynchronous external interrupt line.
REQ-014 SHALL have port ext_ack  in  1  clears the external pending bit, pulsed by the trap handler.
REQ-015 SHALL have ports trint, swint, exint  out  1 each  timer, software and external interrupt lines to the CSR unit.

Function
REQ-016 SHALL map three registers: 0x0000 msip (bit0 only, bits 63:1 read 0); 0x4000 mtimecmp (64b); 0xBFF8 mtime (64b).
REQ-017 SHALL run a two-state FSM: IDLE has req_ready=1; req_valid&&req_ready moves to RESP; RESP moves to IDLE unconditionally.
REQ-018 SHALL raise resp_valid for exactly one cycle in RESP, which is the cycle after acceptance; req_ready=0 in RESP, so throughput is one request per 2 cycles.
REQ-019 SHALL capture read data at acceptance, so resp_rdata shows the value before any same-cycle increment.
REQ-020 SHALL commit a write at acceptance, visible from the next cycle.
REQ-021 SHALL handle an unmapped address as: read returns 0, write is ignored, resp_err=1 with resp_valid.
REQ-022 SHALL increment mtime by 1 every cycle and wrap 0xFFFF_FFFF_FFFF_FFFF -> 0.
REQ-023 SHALL give a same-cycle mtime write priority over the increment; the next cycle holds the written value exactly.
REQ-024 SHALL drive trint as a registered output = (mtime >= mtimecmp), unsigned 64b compare, updated every cycle.
REQ-025 SHALL drive swint as a registered output = msip[0].
REQ-026 SHALL synchronize ext_irq_in through SYNC_STAGES flops; a synchronized 0->1 edge sets ext_pend.
REQ-027 SHALL clear ext_pend on ext_ack; if set and clear occur in the same cycle, set wins.
REQ-028 SHALL drive exint = ext_pend as a registered output.

Reset
REQ-029 SHALL, on reset, set mtime=0, mtimecmp=0xFFFF_FFFF_FFFF_FFFF, msip=0, ext_pend=0, synchronizer flops=0, FSM=IDLE.
REQ-030 SHALL hold these outputs during and after reset: req_ready=1, resp_valid=0, resp_rdata=0, resp_err=0, trint=swint=exint=0.
REQ-031 SHALL drop a request accepted before a mid-transaction reset: no response is issued.

Configuration
REQ-032 SHALL, with macro IRQ_PRESCALE_EN defined, use an 8-bit divider counter: mtime increments only when the counter reaches MTIME_DIV-1, and the counter resets to 0 on reset or on an mtime write.
REQ-033 SHALL, without IRQ_PRESCALE_EN, increment mtime every cycle, and MTIME_DIV SHALL have no effect.

Verification
REQ-034 SHALL cover: reset, then read 0x4000 -> resp_valid one cycle later, rdata=0xFFFF_FFFF_FFFF_FFFF, err=0, trint=0.
REQ-035 SHALL cover: write mtimecmp=20 at cycle 0, no prescale -> trint rises once mtime>=20 (registered), and stays high until mtimecmp is rewritten to 0xFFFF_FFFF_FFFF_FFFF.
REQ-036 SHALL cover: write mtime=0xFFFF_FFFF_FFFF_FFFE -> two cycles later mtime=0 (wrap), and a read shows the wrapped value.
REQ-037 SHALL cover: write msip=0xFFFF_FFFF_FFFF_FFFF -> swint=1 next cycle, read returns 1; write 0 -> swint=0.
REQ-038 SHALL cover: ext_irq_in pulse -> exint=1 after SYNC_STAGES+2 cycles; ext_ack in the same cycle as a new edge -> exint stays 1.
REQ-039 SHALL cover: req_valid held for 4 cycles at 0x1234 -> two accepts, resp_err=1 each time, req_ready low in every RESP cycle.
